reminder_scheduler: RTL and testbench
=====================================

// Module: reminder_scheduler
// PURPOSE
//  Programmable reminder controller fed by the 1 pps timebase. Holds NUM_SLOTS reminder
//  times-of-day and matches each against a wrapping seconds-of-day counter. Arbitrates
//  among due reminders, one alert at a time, and drives the led/cube indicators.
//  Handles user acknowledge from stop_sw and automatic snooze. Sits between the
//  timebase and the board output registers.
// PARAMETERS
//  NUM_SLOTS    8      reminder slots; also the led width; one led per slot
//  SEC_W        17     seconds-of-day width; 2^17 > 86400
//  DAY_SECONDS  86400  day_sec wraps to 0 after DAY_SECONDS-1
//  TIMEOUT_SEC  60     unacknowledged alert duration before auto-snooze, in ticks
//  SNOOZE_SEC   300    re-alert delay after a timeout
// PORTS
//  clk_int    in   1          system clock
//  rst_int    in   1          asynchronous reset, active-low
//  tick_1s    in   1          one-cycle pulse, once per second, synchronous to clk_int
//  ack        in   1          stop_sw level, already synchronised; rising edge detected internally
//  cfg_we     in   1          write strobe for the slot table
//  cfg_idx    in   3          slot index; $clog2(NUM_SLOTS)
//  cfg_time   in   SEC_W      reminder time-of-day in seconds
//  cfg_en     in   1          slot enable written with cfg_time
//  cfg_err    out  1          one-cycle pulse: write rejected
//  day_sec    out  SEC_W      current seconds-of-day
//  led        out  NUM_SLOTS  one-hot of the alerting slot; 0 when idle
//  cube       out  1          1 while any alert is active
//  pending    out  NUM_SLOTS  due-but-unserved slots
// BEHAVIOUR
//  Reset (async, rst_int=0):
//   - All outputs are 0; day_sec=0.
//   - All slots are disabled; pending=0; snooze_valid=0; FSM=IDLE.
//  Time counter:
//   - On tick_1s, day_sec <= (day_sec==DAY_SECONDS-1) ? 0 : day_sec+1.
//  Match:
//   - On a tick edge, enabled slot i gets pending[i]<=1 if time[i]==next day_sec.
//   - On a tick edge, slot i with snooze_valid[i] gets pending[i]<=1 if
//     snooze_time[i]==next day_sec; snooze_valid[i] clears in the same edge.
//   - pending is visible 1 cycle after the tick cycle.
//  Arbitration:
//   - Fixed priority: lowest pending index wins.
//   - A running alert is never pre-empted.
//  FSM:
//   - IDLE -> ALERT on the first edge where pending!=0; latch act_idx.
//   - In ALERT: led=1<<act_idx, cube=1, all registered.
//   - Total latency is 2 cycles after the tick cycle.
//   - ALERT, ack rising edge: clear pending[act_idx]; go to IDLE. led/cube=0 next cycle.
//     Any other pending slot starts its alert 1 cycle later.
//   - ALERT, TIMEOUT_SEC ticks counted: clear pending[act_idx].
//     Set snooze_time=(day_sec+SNOOZE_SEC) mod DAY_SECONDS; set snooze_valid; go to IDLE.
//   - The tick count starts at 0 on ALERT entry.
//  Config:
//   - cfg_we with cfg_time>=DAY_SECONDS: write ignored; cfg_err pulses.
//   - cfg_en=0: slot disabled; pending and snooze_valid for that slot cleared.
//     If that slot is the active one, alert ends; IDLE next edge.
//   - Rewrite of the active slot with cfg_en=1: alert continues; new time applies to the next match.
//  Simultaneous events:
//   - ack edge and timeout on the same edge: ack wins; no snooze.
//   - tick with ack: day_sec still advances; new matches are still recorded.
//   - cfg write and match on the same slot in the same edge: match uses the old table value.
//   - Snooze and base time coincide: single pending bit; one alert.
//  Held ack: only a rising edge acknowledges. A held stop_sw does not ack later alerts.
// STRUCTURE
//  Package reminder_pkg holds:
//   - DAY_SECONDS, SEC_W, TIMEOUT_SEC, SNOOZE_SEC
//   - state enum {IDLE, ALERT}
//   - slot struct {en, time, snooze_valid, snooze_time}
//  Sub-module reminder_slot, generated NUM_SLOTS times:
//   - table registers, match compare, pending/snooze bits
//   - set/clear inputs from the top
//  Top holds: day counter, priority encoder, FSM, timeout counter, ack edge detect, output registers.
// TESTING
//  1. Slot0=60, en. Reset, 60 ticks -> pending[0] 1 cycle after tick 60.
//     led=8'h01 and cube=1 2 cycles after that tick. ack edge -> led=0, cube=0 next cycle.
//  2. Slots 2 and 5 both =10. At tick 10: led=8'h04 first. ack -> led=8'h20 1 cycle after IDLE.
//  3. Slot3=100, no ack. 60 ticks -> led=0. At day_sec 460 -> led=8'h08 again.
//  4. day_sec preloaded via 86399 ticks; slot1=0 -> next tick day_sec=0, led=8'h02.
//     Snooze from day_sec=86200 re-alerts at 100.
//  5. cfg_time=86400 -> cfg_err 1-cycle pulse; table unchanged.
//     cfg_en=0 on the active slot -> led=0 within 2 cycles.
//  6. Assert rst_int mid-ALERT -> all outputs 0 immediately; no alert after release until a new match.

Source files
------------

// File: rtl/reminder_pkg.sv
// Shared types and default constants for the reminder scheduler.
// The slot struct describes one entry of the reminder table.
package reminder_pkg;

    localparam int NUM_SLOTS   = 8;
    localparam int SEC_W       = 17;
    localparam int DAY_SECONDS = 86400;
    localparam int TIMEOUT_SEC = 60;
    localparam int SNOOZE_SEC  = 300;

    typedef enum logic {
        IDLE  = 1'b0,
        ALERT = 1'b1
    } state_t;

    typedef struct packed {
        logic             en;
        logic [SEC_W-1:0] tod;
        logic             snooze_valid;
        logic [SEC_W-1:0] snooze_time;
    } slot_t;

endpackage

// File: rtl/reminder_slot.sv
// One reminder table entry: programmed time, snooze time and the due (pending) flag.
// Matches compare against the seconds value that the day counter takes on this tick.
module reminder_slot
    import reminder_pkg::*;
(
    input  logic             clk_int,
    input  logic             rst_int,
    input  logic             tick_1s,
    input  logic [SEC_W-1:0] day_next,
    input  logic             cfg_we,
    input  logic             cfg_en,
    input  logic [SEC_W-1:0] cfg_time,
    input  logic             clr_pending,
    input  logic             snz_set,
    input  logic [SEC_W-1:0] snz_time,
    output logic             pending
);

    slot_t slot_q;
    logic  hit_base;
    logic  hit_snz;
    logic  disable_w;

    // Compares use the registered table, so a same-edge write only affects later matches.
    assign hit_base  = tick_1s & slot_q.en & (slot_q.tod == day_next);
    assign hit_snz   = tick_1s & slot_q.snooze_valid & (slot_q.snooze_time == day_next);
    assign disable_w = cfg_we & ~cfg_en;

    always_ff @(posedge clk_int or negedge rst_int) begin
        if (!rst_int) begin
            slot_q  <= '0;
            pending <= 1'b0;
        end else begin
            if (cfg_we) begin
                slot_q.en  <= cfg_en;
                slot_q.tod <= cfg_time;
            end

            if (disable_w) begin
                slot_q.snooze_valid <= 1'b0;
            end else if (snz_set) begin
                slot_q.snooze_valid <= 1'b1;
                slot_q.snooze_time  <= snz_time;
            end else if (hit_snz) begin
                slot_q.snooze_valid <= 1'b0;
            end

            // A fresh match outranks the clear from ack/timeout of the same edge.
            if (disable_w) begin
                pending <= 1'b0;
            end else if (hit_base | hit_snz) begin
                pending <= 1'b1;
            end else if (clr_pending) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reminder_scheduler.sv
// Reminder controller: seconds-of-day counter, slot table, fixed-priority arbitration,
// single-alert FSM with acknowledge, timeout and snooze, and registered indicators.
module reminder_scheduler
    import reminder_pkg::*;
#(
    parameter int NUM_SLOTS   = reminder_pkg::NUM_SLOTS,
    parameter int SEC_W       = reminder_pkg::SEC_W,
    parameter int DAY_SECONDS = reminder_pkg::DAY_SECONDS,
    parameter int TIMEOUT_SEC = reminder_pkg::TIMEOUT_SEC,
    parameter int SNOOZE_SEC  = reminder_pkg::SNOOZE_SEC
) (
    input  logic                         clk_int,
    input  logic                         rst_int,
    input  logic                         tick_1s,
    input  logic                         ack,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_idx,
    input  logic [SEC_W-1:0]             cfg_time,
    input  logic                         cfg_en,
    output logic                         cfg_err,
    output logic [SEC_W-1:0]             day_sec,
    output logic [NUM_SLOTS-1:0]         led,
    output logic                         cube,
    output logic [NUM_SLOTS-1:0]         pending
);

    localparam int               IDX_W    = $clog2(NUM_SLOTS);
    localparam int               TMO_W    = $clog2(TIMEOUT_SEC + 1);
    localparam logic [SEC_W-1:0] DAY_LAST = SEC_W'(DAY_SECONDS - 1);
    localparam logic [SEC_W:0]   DAY_LIM  = (SEC_W + 1)'(DAY_SECONDS);
    localparam logic [SEC_W-1:0] SNZ_OFS  = SEC_W'(SNOOZE_SEC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_SEC - 1);

    function automatic logic [SEC_W-1:0] inc_wrap(input logic [SEC_W-1:0] s);
        return (s == DAY_LAST) ? '0 : s + 1'b1;
    endfunction

    function automatic logic [SEC_W-1:0] add_wrap(input logic [SEC_W-1:0] s,
                                                  input logic [SEC_W-1:0] d);
        logic [SEC_W:0] sum;
        sum = {1'b0, s} + {1'b0, d};
        if (sum >= DAY_LIM) begin
            sum = sum - DAY_LIM;
        end
        return sum[SEC_W-1:0];
    endfunction

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     act_idx;
    logic [IDX_W-1:0]     win_idx;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 ack_q;
    logic                 ack_rise;
    logic                 timeout;
    logic                 cfg_ok;
    logic                 kill_act;
    logic [SEC_W-1:0]     day_next;
    logic [SEC_W-1:0]     snz_time;
    logic [NUM_SLOTS-1:0] slot_we;
    logic [NUM_SLOTS-1:0] clr_vec;
    logic [NUM_SLOTS-1:0] snz_vec;
    logic [NUM_SLOTS-1:0] led_nxt;
    logic                 cube_nxt;

    assign day_next = inc_wrap(day_sec);
    // Snooze is measured from the seconds value that becomes current on the timeout edge.
    assign snz_time = add_wrap(day_next, SNZ_OFS);
    assign ack_rise = ack & ~ack_q;
    assign cfg_ok   = cfg_we & ({1'b0, cfg_time} < DAY_LIM);
    assign timeout  = (state == ALERT) & tick_1s & (tmo_cnt == TMO_LAST);
    assign kill_act = slot_we[act_idx] & ~cfg_en;

    always_comb begin
        slot_we = '0;
        if (cfg_ok) begin
            slot_we[cfg_idx] = 1'b1;
        end
    end

    // Lowest pending index wins.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        clr_vec   = '0;
        snz_vec   = '0;
        led_nxt   = led;
        cube_nxt  = cube;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nxt        = ALERT;
                    led_nxt          = '0;
                    led_nxt[win_idx] = 1'b1;
                    cube_nxt         = 1'b1;
                end
            end
            ALERT: begin
                // Ack is checked before timeout so a coincident ack suppresses the snooze.
                if (kill_act) begin
                    state_nxt = IDLE;
                    led_nxt   = '0;
                    cube_nxt  = 1'b0;
                end else if (ack_rise) begin
                    state_nxt        = IDLE;
                    clr_vec[act_idx] = 1'b1;
                    led_nxt          = '0;
                    cube_nxt         = 1'b0;
                end else if (timeout) begin
                    state_nxt        = IDLE;
                    clr_vec[act_idx] = 1'b1;
                    snz_vec[act_idx] = 1'b1;
                    led_nxt          = '0;
                    cube_nxt         = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                led_nxt   = '0;
                cube_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_int or negedge rst_int) begin
        if (!rst_int) begin
            day_sec <= '0;
            ack_q   <= 1'b0;
            cfg_err <= 1'b0;
            state   <= IDLE;
            act_idx <= '0;
            tmo_cnt <= '0;
            led     <= '0;
            cube    <= 1'b0;
        end else begin
            if (tick_1s) begin
                day_sec <= day_next;
            end
            ack_q   <= ack;
            cfg_err <= cfg_we & ~cfg_ok;
            state   <= state_nxt;
            led     <= led_nxt;
            cube    <= cube_nxt;
            if (state == IDLE && state_nxt == ALERT) begin
                act_idx <= win_idx;
            end
            if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tick_1s) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        reminder_slot u_slot (
            .clk_int     (clk_int),
            .rst_int     (rst_int),
            .tick_1s     (tick_1s),
            .day_next    (day_next),
            .cfg_we      (slot_we[g]),
            .cfg_en      (cfg_en),
            .cfg_time    (cfg_time),
            .clr_pending (clr_vec[g]),
            .snz_set     (snz_vec[g]),
            .snz_time    (snz_time),
            .pending     (pending[g])
        );
    end

endmodule

// File: tb/tb_reminder_scheduler.sv
// Directed bench for reminder_scheduler: match, arbitration, ack, timeout/snooze,
// day wrap, config rejection/disable and asynchronous reset.
module tb_reminder_scheduler;

    logic        clk_int = 1'b0;
    logic        rst_int = 1'b0;
    logic        tick_1s = 1'b0;
    logic        ack     = 1'b0;
    logic        cfg_we  = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [16:0] cfg_time = '0;
    logic        cfg_en  = 1'b0;
    logic        cfg_err;
    logic [16:0] day_sec;
    logic [7:0]  led;
    logic        cube;
    logic [7:0]  pending;

    int checks = 0;
    int errors = 0;

    reminder_scheduler dut (
        .clk_int  (clk_int),
        .rst_int  (rst_int),
        .tick_1s  (tick_1s),
        .ack      (ack),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_time (cfg_time),
        .cfg_en   (cfg_en),
        .cfg_err  (cfg_err),
        .day_sec  (day_sec),
        .led      (led),
        .cube     (cube),
        .pending  (pending)
    );

    always #5 clk_int = ~clk_int;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_int);
        rst_int = 1'b0;
        repeat (2) @(negedge clk_int);
        rst_int = 1'b1;
        @(negedge clk_int);
    endtask

    task automatic cfg_write(input int idx, input int t, input logic en);
        cfg_idx  = 3'(idx);
        cfg_time = 17'(t);
        cfg_en   = en;
        cfg_we   = 1'b1;
        @(negedge clk_int);
        cfg_we   = 1'b0;
    endtask

    // Returns one cycle after the tick cycle.
    task automatic tick_pulse();
        tick_1s = 1'b1;
        @(negedge clk_int);
        tick_1s = 1'b0;
    endtask

    // Returns two cycles after the last tick cycle.
    task automatic ticks(input int n);
        repeat (n) begin
            tick_pulse();
            @(negedge clk_int);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_int);
        chk("rst_day", 32'(day_sec), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_cube", 32'(cube), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst_int = 1'b1;
        @(negedge clk_int);

        // Test 1: slot0 at 60
        cfg_write(0, 60, 1'b1);
        chk("t1_cfg_err", 32'(cfg_err), 32'd0);
        ticks(59);
        chk("t1_day59", 32'(day_sec), 32'd59);
        chk("t1_led_early", 32'(led), 32'd0);
        tick_pulse();
        chk("t1_pending", 32'(pending), 32'h01);
        chk("t1_led_not_yet", 32'(led), 32'd0);
        @(negedge clk_int);
        chk("t1_led", 32'(led), 32'h01);
        chk("t1_cube", 32'(cube), 32'd1);
        ack = 1'b1;
        @(negedge clk_int);
        ack = 1'b0;
        chk("t1_ack_led", 32'(led), 32'd0);
        chk("t1_ack_cube", 32'(cube), 32'd0);
        chk("t1_ack_pending", 32'(pending), 32'd0);

        // Test 2: slots 2 and 5 both at 10, priority and held ack
        do_reset();
        chk("t2_day0", 32'(day_sec), 32'd0);
        cfg_write(2, 10, 1'b1);
        cfg_write(5, 10, 1'b1);
        ticks(9);
        tick_pulse();
        chk("t2_pending", 32'(pending), 32'h24);
        @(negedge clk_int);
        chk("t2_led_first", 32'(led), 32'h04);
        ack = 1'b1;
        @(negedge clk_int);
        chk("t2_led_idle", 32'(led), 32'd0);
        chk("t2_pending_left", 32'(pending), 32'h20);
        @(negedge clk_int);
        chk("t2_led_second", 32'(led), 32'h20);
        repeat (3) @(negedge clk_int);
        chk("t2_held_ack", 32'(led), 32'h20);
        ack = 1'b0;
        @(negedge clk_int);
        ack = 1'b1;
        @(negedge clk_int);
        ack = 1'b0;
        chk("t2_ack2_led", 32'(led), 32'd0);
        chk("t2_ack2_pending", 32'(pending), 32'd0);

        // Test 3: slot3 at 100, timeout and snooze to 460, then ack racing timeout
        do_reset();
        cfg_write(3, 100, 1'b1);
        ticks(100);
        chk("t3_led", 32'(led), 32'h08);
        ticks(59);
        chk("t3_led_before_tmo", 32'(led), 32'h08);
        tick_pulse();
        chk("t3_tmo_led", 32'(led), 32'd0);
        chk("t3_tmo_pending", 32'(pending), 32'd0);
        chk("t3_tmo_day", 32'(day_sec), 32'd160);
        @(negedge clk_int);
        ticks(299);
        chk("t3_day459", 32'(day_sec), 32'd459);
        chk("t3_led_459", 32'(led), 32'd0);
        ticks(1);
        chk("t3_snooze_led", 32'(led), 32'h08);
        ticks(59);
        chk("t3_snooze_hold", 32'(led), 32'h08);
        tick_1s = 1'b1;
        ack     = 1'b1;
        @(negedge clk_int);
        tick_1s = 1'b0;
        ack     = 1'b0;
        chk("t3_ack_tmo_led", 32'(led), 32'd0);
        chk("t3_ack_tmo_day", 32'(day_sec), 32'd520);
        @(negedge clk_int);
        ticks(300);
        chk("t3_no_snooze_led", 32'(led), 32'd0);
        chk("t3_no_snooze_pend", 32'(pending), 32'd0);

        // Test 5: config rejection, boundary, disable of the active slot
        cfg_write(4, 830, 1'b1);
        chk("t5_ok_err", 32'(cfg_err), 32'd0);
        cfg_write(4, 86400, 1'b0);
        chk("t5_err_pulse", 32'(cfg_err), 32'd1);
        @(negedge clk_int);
        chk("t5_err_drop", 32'(cfg_err), 32'd0);
        cfg_write(7, 86399, 1'b1);
        chk("t5_edge_err", 32'(cfg_err), 32'd0);
        ticks(10);
        chk("t5_table_kept", 32'(led), 32'h10);
        cfg_write(4, 830, 1'b0);
        chk("t5_kill_led", 32'(led), 32'd0);
        chk("t5_kill_cube", 32'(cube), 32'd0);
        chk("t5_kill_pending", 32'(pending), 32'd0);

        // Test 6: asynchronous reset in the middle of an alert
        cfg_write(4, 840, 1'b1);
        ticks(10);
        chk("t6_led", 32'(led), 32'h10);
        #2;
        rst_int = 1'b0;
        #1;
        chk("t6_async_led", 32'(led), 32'd0);
        chk("t6_async_cube", 32'(cube), 32'd0);
        chk("t6_async_day", 32'(day_sec), 32'd0);
        chk("t6_async_pending", 32'(pending), 32'd0);
        @(negedge clk_int);
        rst_int = 1'b1;
        @(negedge clk_int);
        ticks(5);
        chk("t6_no_alert", 32'(led), 32'd0);
        chk("t6_day5", 32'(day_sec), 32'd5);

        // Test 4: day wrap with slot1 at 0, snooze from 86200 wrapping to 100
        do_reset();
        cfg_write(6, 86140, 1'b1);
        cfg_write(1, 0, 1'b1);
        tick_1s = 1'b1;
        repeat (86130) @(negedge clk_int);
        tick_1s = 1'b0;
        chk("t4_day86130", 32'(day_sec), 32'd86130);
        chk("t4_quiet", 32'(led), 32'd0);
        @(negedge clk_int);
        ticks(10);
        chk("t4_led6", 32'(led), 32'h40);
        ticks(59);
        chk("t4_led6_hold", 32'(led), 32'h40);
        tick_pulse();
        chk("t4_tmo_led", 32'(led), 32'd0);
        chk("t4_tmo_day", 32'(day_sec), 32'd86200);
        @(negedge clk_int);
        ticks(199);
        chk("t4_day86399", 32'(day_sec), 32'd86399);
        tick_pulse();
        chk("t4_wrap_day", 32'(day_sec), 32'd0);
        chk("t4_wrap_pending", 32'(pending), 32'h02);
        @(negedge clk_int);
        chk("t4_wrap_led", 32'(led), 32'h02);
        ack = 1'b1;
        @(negedge clk_int);
        ack = 1'b0;
        chk("t4_ack_led", 32'(led), 32'd0);
        ticks(100);
        chk("t4_snooze_day", 32'(day_sec), 32'd100);
        chk("t4_snooze_led", 32'(led), 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
